// File: rtl/dso_pkg.sv
// Shared definitions for the capture/dump datapath: buffer geometry,
// channel count and the dump controller state encoding.
package dso_pkg;

  // Samples held per channel RAM; also the number of bytes in one dump.
  localparam int ENTRIES  = 384;
  // RAM address width; 2**LOG2 must cover ENTRIES.
  localparam int LOG2     = 9;
  // Number of capture channels (valid channel indices 0..NUM_CHAN-1).
  localparam int NUM_CHAN = 5;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    LOAD,
    XMIT,
    WAIT_TX,
    DONE
  } dump_state_t;

endpackage

// File: rtl/circ_addr_cnt.sv
// Circular address counter over 0..ENTRIES-1. A load takes priority over an
// increment, and a load value outside the buffer starts from address 0.
// Shared by capture_cntrl (write pointer) and dump_ctrl (read pointer).
module circ_addr_cnt
  import dso_pkg::*;
#(
  parameter int CNT_ENTRIES = ENTRIES,
  parameter int CNT_LOG2    = LOG2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [CNT_LOG2-1:0] load_val,
  input  logic                inc,
  output logic [CNT_LOG2-1:0] cnt
);

  localparam logic [CNT_LOG2-1:0] LAST = CNT_LOG2'(CNT_ENTRIES - 1);

  // Address register: load, or step forward and wrap after the last entry.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (load_val > LAST) ? '0 : load_val;
    end else if (inc) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dump_ctrl.sv
// Dump controller: once a capture is frozen, streams one channel's circular
// sample RAM to the UART transmitter, oldest sample first, one byte per
// read/load/transmit/wait round trip. All outputs come straight from flops.
module dump_ctrl
  import dso_pkg::*;
#(
  parameter int ENTRIES = dso_pkg::ENTRIES,
  parameter int LOG2    = dso_pkg::LOG2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dump_start,
  input  logic [2:0]      dump_chan,
  input  logic            capture_done,
  input  logic [LOG2-1:0] waddr,
  input  logic [7:0]      rdata,
  input  logic            tx_done,
  output logic            rd_en,
  output logic [LOG2-1:0] raddr,
  output logic [2:0]      ram_sel,
  output logic [7:0]      tx_data,
  output logic            trmt,
  output logic            dumping,
  output logic            dump_done,
  output logic            dump_err
);

  localparam logic [LOG2-1:0] LAST_BYTE = LOG2'(ENTRIES - 1);
  localparam logic [2:0]      LAST_CHAN = 3'(NUM_CHAN - 1);

  dump_state_t     state;
  logic [LOG2-1:0] count;     // bytes already handed off in this dump
  logic            start_ok;  // start request that will be accepted
  logic            addr_load;
  logic            addr_inc;

  assign start_ok  = dump_start && capture_done && (dump_chan <= LAST_CHAN);

  // The read pointer is loaded with the oldest sample on an accepted start and
  // advances after every byte except the last, so one dump covers one lap.
  assign addr_load = (state == IDLE) && start_ok;
  assign addr_inc  = (state == WAIT_TX) && tx_done && (count != LAST_BYTE);

  circ_addr_cnt #(
    .CNT_ENTRIES (ENTRIES),
    .CNT_LOG2    (LOG2)
  ) u_raddr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (addr_load),
    .load_val (waddr),
    .inc      (addr_inc),
    .cnt      (raddr)
  );

  // Dump sequencer with registered strobes, channel select and byte buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      ram_sel   <= '0;
      tx_data   <= '0;
      rd_en     <= 1'b0;
      trmt      <= 1'b0;
      dumping   <= 1'b0;
      dump_done <= 1'b0;
      dump_err  <= 1'b0;
    end else begin
      // NOTE: single-cycle strobes default low here and are raised only in the
      // branch that issues them, so none can stick high across states.
      rd_en     <= 1'b0;
      trmt      <= 1'b0;
      dump_done <= 1'b0;
      dump_err  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (start_ok) begin
            ram_sel <= dump_chan;
            count   <= '0;
            dumping <= 1'b1;
            rd_en   <= 1'b1;
            state   <= RD;
          end else if (dump_start) begin
            dump_err <= 1'b1;
          end
        end

        // rd_en is high during this state; RAM data arrives next cycle.
        RD: state <= LOAD;

        // Capture the RAM byte; it stays on tx_data until the UART is done.
        LOAD: begin
          tx_data <= rdata;
          trmt    <= 1'b1;
          state   <= XMIT;
        end

        // trmt is high during this state; tx_done here is not yet meaningful.
        XMIT: state <= WAIT_TX;

        WAIT_TX: begin
          if (tx_done) begin
            if (count == LAST_BYTE) begin
              dump_done <= 1'b1;
              state     <= DONE;
            end else begin
              count <= count + 1'b1;
              rd_en <= 1'b1;
              state <= RD;
            end
          end
        end

        // dump_done is high during this state; dumping drops with the exit.
        DONE: begin
          dumping <= 1'b0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dump_ctrl.sv
// Self-checking bench for dump_ctrl. A reference model expands each accepted
// start into the expected address/byte stream; a negedge monitor pops and
// compares it whenever the DUT strobes rd_en or trmt. A responder plays the
// UART, answering each trmt with tx_done after a fixed or random delay.
module tb_dump_ctrl;
  import dso_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       dump_start;
  logic [2:0] dump_chan;
  logic       capture_done;
  logic [8:0] waddr;
  logic [7:0] rdata;
  logic       tx_done;
  logic       rd_en;
  logic [8:0] raddr;
  logic [2:0] ram_sel;
  logic [7:0] tx_data;
  logic       trmt;
  logic       dumping;
  logic       dump_done;
  logic       dump_err;

  logic tx_done_resp;
  logic tx_done_spur;
  assign tx_done = tx_done_resp | tx_done_spur;

  dump_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dump_start   (dump_start),
    .dump_chan    (dump_chan),
    .capture_done (capture_done),
    .waddr        (waddr),
    .rdata        (rdata),
    .tx_done      (tx_done),
    .rd_en        (rd_en),
    .raddr        (raddr),
    .ram_sel      (ram_sel),
    .tx_data      (tx_data),
    .trmt         (trmt),
    .dumping      (dumping),
    .dump_done    (dump_done),
    .dump_err     (dump_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Channel RAMs with a one-cycle registered read.
  logic [7:0] mem [NUM_CHAN][ENTRIES];
  always @(posedge clk) begin
    if (rd_en) begin
      if (ram_sel < NUM_CHAN && raddr < ENTRIES) rdata <= mem[ram_sel][raddr];
      else rdata <= 8'h00;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard state.
  int         exp_addr_q[$];
  logic [7:0] exp_byte_q[$];
  int         exp_chan = 0;
  int         rd_seen = 0, trmt_seen = 0, done_seen = 0, err_seen = 0;
  int         exp_done = 0, exp_err = 0;
  bit         waiting = 0;
  logic [7:0] last_tx;
  int         tx_delay = 10;
  int         resp_d;

  // Reference model: a dump reads every address once, oldest first.
  task automatic push_dump(input int chan, input int wa);
    int start;
    start = (wa >= ENTRIES) ? 0 : wa;
    for (int k = 0; k < ENTRIES; k++) begin
      exp_addr_q.push_back((start + k) % ENTRIES);
      exp_byte_q.push_back(mem[chan][(start + k) % ENTRIES]);
    end
    exp_chan = chan;
  endtask

  // Monitor: compares every strobe against the expected stream.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_en) begin
        rd_seen++;
        if (exp_addr_q.size() == 0) check("unexpected_rd_en", 32'd1, 32'd0);
        else check("raddr", 32'(raddr), 32'(exp_addr_q.pop_front()));
      end
      if (trmt) begin
        trmt_seen++;
        if (exp_byte_q.size() == 0) check("unexpected_trmt", 32'd1, 32'd0);
        else begin
          check("tx_data", 32'(tx_data), 32'(exp_byte_q.pop_front()));
          check("ram_sel", 32'(ram_sel), 32'(exp_chan));
        end
        last_tx = tx_data;
        waiting = 1'b1;
      end else if (tx_done && waiting) begin
        check("tx_data_hold", 32'(tx_data), 32'(last_tx));
        waiting = 1'b0;
      end
      if (dump_done) begin
        done_seen++;
        check("bytes_left_at_done", 32'(exp_byte_q.size()), 32'd0);
      end
      if (dump_err) err_seen++;
    end
  end

  // UART stand-in: tx_done a fixed (or random, if tx_delay==0) time after trmt.
  initial begin
    tx_done_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (trmt) begin
        resp_d = (tx_delay > 0) ? tx_delay : int'($urandom_range(1, 6));
        repeat (resp_d) @(posedge clk);
        #1 tx_done_resp = 1'b1;
        @(posedge clk);
        #1 tx_done_resp = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int chan, input int wa, input bit accept);
    dump_chan  = 3'(chan);
    waddr      = 9'(wa);
    dump_start = 1'b1;
    if (accept) push_dump(chan, wa);
    tick();
    dump_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (dump_done) seen = 1'b1;
    end
    check("dump_done_within_budget", 32'(seen), 32'd1);
    exp_done++;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_en"},     32'(rd_en),     32'd0);
    check({tag, "_raddr"},     32'(raddr),     32'd0);
    check({tag, "_ram_sel"},   32'(ram_sel),   32'd0);
    check({tag, "_tx_data"},   32'(tx_data),   32'd0);
    check({tag, "_trmt"},      32'(trmt),      32'd0);
    check({tag, "_dumping"},   32'(dumping),   32'd0);
    check({tag, "_dump_done"}, 32'(dump_done), 32'd0);
    check({tag, "_dump_err"},  32'(dump_err),  32'd0);
  endtask

  int t0, r0, base;
  int rej_chan [3] = '{1, 5, 7};
  bit rej_cd   [3] = '{1'b0, 1'b1, 1'b1};

  initial begin
    rst_n        = 1'b0;
    dump_start   = 1'b0;
    dump_chan    = '0;
    capture_done = 1'b0;
    waddr        = '0;
    tx_done_spur = 1'b0;
    for (int c = 0; c < NUM_CHAN; c++)
      for (int a = 0; a < ENTRIES; a++) mem[c][a] = 8'($urandom);
    for (int a = 0; a < ENTRIES; a++) mem[2][a] = 8'(a);

    // Reset state.
    repeat (3) tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    // Basic dump: channel 2, waddr 0, tx_done 10 cycles after each trmt.
    capture_done = 1'b1;
    tx_delay     = 10;
    t0 = trmt_seen;
    r0 = rd_seen;
    do_start(2, 0, 1'b1);
    wait_done(8000);
    check("basic_dumping_at_done", 32'(dumping), 32'd1);
    check("basic_trmt_count", 32'(trmt_seen - t0), 32'(ENTRIES));
    check("basic_rd_count", 32'(rd_seen - r0), 32'(ENTRIES));
    tick();
    check("basic_dumping_after", 32'(dumping), 32'd0);
    check("basic_done_pulse_1cyc", 32'(dump_done), 32'd0);
    repeat (3) tick();

    // Timing and wrap: start at 380, spurious tx_done in RD and XMIT,
    // a second start mid-dump, and capture_done dropping mid-dump.
    tx_delay = 4;
    r0 = rd_seen;
    do_start(3, 380, 1'b1);
    check("t_rd_en_n1", 32'(rd_en), 32'd1);
    check("t_trmt_n1", 32'(trmt), 32'd0);
    check("t_dumping_n1", 32'(dumping), 32'd1);
    check("t_ram_sel", 32'(ram_sel), 32'd3);
    tx_done_spur = 1'b1;
    tick();
    tx_done_spur = 1'b0;
    check("t_rd_en_n2", 32'(rd_en), 32'd0);
    check("t_trmt_n2", 32'(trmt), 32'd0);
    dump_chan  = 3'd0;
    waddr      = 9'd7;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    check("t_trmt_n3", 32'(trmt), 32'd1);
    check("t_tx_data_n3", 32'(tx_data), 32'(mem[3][380]));
    tx_done_spur = 1'b1;
    tick();
    tx_done_spur = 1'b0;
    check("t_trmt_n4", 32'(trmt), 32'd0);
    check("t_spur_xmit_rd_en", 32'(rd_en), 32'd0);
    check("t_mid_start_no_err", 32'(dump_err), 32'd0);
    check("t_mid_start_ram_sel", 32'(ram_sel), 32'd3);
    tx_delay     = 0;
    capture_done = 1'b0;
    wait_done(8000);
    check("wrap_rd_count", 32'(rd_seen - r0), 32'(ENTRIES));
    capture_done = 1'b1;
    repeat (3) tick();

    // Rejected starts: no capture, channel 5, channel 7.
    for (int i = 0; i < 3; i++) begin
      capture_done = rej_cd[i];
      do_start(rej_chan[i], 0, 1'b0);
      check("reject_err_pulse", 32'(dump_err), 32'd1);
      check("reject_no_rd_en", 32'(rd_en), 32'd0);
      check("reject_not_dumping", 32'(dumping), 32'd0);
      tick();
      check("reject_err_1cyc", 32'(dump_err), 32'd0);
      exp_err++;
      repeat (2) tick();
    end
    capture_done = 1'b1;

    // Reset after 100 bytes, then a full dump from a new write pointer.
    base = trmt_seen;
    do_start(1, 50, 1'b1);
    for (int i = 0; i < 5000; i++) begin
      tick();
      if (trmt_seen - base >= 100) break;
    end
    check("reset_reached_100_bytes", 32'(trmt_seen - base >= 100), 32'd1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    exp_addr_q.delete();
    exp_byte_q.delete();
    waiting = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    t0 = trmt_seen;
    do_start(4, 200, 1'b1);
    wait_done(8000);
    check("post_reset_trmt_count", 32'(trmt_seen - t0), 32'(ENTRIES));
    repeat (3) tick();

    // Back-to-back: restart on the first IDLE cycle; out-of-range waddr -> 0.
    do_start(0, 100, 1'b1);
    wait_done(8000);
    tick();
    check("b2b_gap_dumping_low", 32'(dumping), 32'd0);
    do_start(1, 500, 1'b1);
    check("b2b_dumping_high_again", 32'(dumping), 32'd1);
    check("b2b_clamped_raddr", 32'(raddr), 32'd0);
    wait_done(8000);
    repeat (3) tick();

    // One randomized dump.
    base = int'($urandom_range(0, NUM_CHAN - 1));
    do_start(base, int'($urandom_range(0, 511)), 1'b1);
    wait_done(8000);
    repeat (15) tick();

    check("total_dump_done_pulses", 32'(done_seen), 32'(exp_done));
    check("total_dump_err_pulses", 32'(err_seen), 32'(exp_err));
    check("stream_fully_consumed", 32'(exp_addr_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
